// File: rtl/kv_line_fetcher_if.sv
// rtl/kv_line_fetcher_if.sv - request, line-response and memory-read channels of kv_line_fetcher
// Member names keep their i_/o_ prefixes because i_mem_valid and o_mem_valid would otherwise collide.
interface kv_line_fetcher_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 4
);
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  i_req_valid;
  logic                  o_req_ready;

  logic [DATA_WIDTH-1:0] o_line_data [LINE_SIZE-1:0];
  logic [ADDR_WIDTH-1:0] o_line_addr;
  logic                  o_line_valid;
  logic                  i_line_ready;

  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_valid;
  logic                  i_mem_ready;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  i_mem_valid;

  modport slave (
    input  i_req_addr, i_req_valid, i_line_ready, i_mem_ready, i_mem_data, i_mem_valid,
    output o_req_ready, o_line_data, o_line_addr, o_line_valid, o_mem_addr, o_mem_valid
  );

  modport master (
    output i_req_addr, i_req_valid, i_line_ready, i_mem_ready, i_mem_data, i_mem_valid,
    input  o_req_ready, o_line_data, o_line_addr, o_line_valid, o_mem_addr, o_mem_valid
  );
endinterface

// File: rtl/kv_line_fetcher.sv
// rtl/kv_line_fetcher.sv - KV-cache line fill engine: issues LINE_SIZE word reads and returns the assembled line
// Optional macro CRITICAL_WORD_FIRST_EN issues reads starting from the requested word (wrapping).
module kv_line_fetcher #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  kv_line_fetcher_if.slave   bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int WB    = $clog2(BYTES);
  localparam int OFS   = $clog2(LINE_SIZE * BYTES);
  localparam int IW    = $clog2(LINE_SIZE);
  localparam int CW    = IW + 1;

  localparam logic [CW-1:0]         LAST_IDX  = CW'(LINE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = {ADDR_WIDTH{1'b1}} << OFS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         recv_cnt;
  logic [DATA_WIDTH-1:0] line_buf [LINE_SIZE-1:0];

  logic [ADDR_WIDTH-1:0] req_base;
  logic [IW-1:0]         req_start;
  logic [IW-1:0]         start;
  logic [CW-1:0]         issue_nxt;
  logic [IW-1:0]         issue_slot_nxt;
  logic [IW-1:0]         recv_slot;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IW-1:0] start_q;
  assign req_start = bus.i_req_addr[OFS-1:WB];
  assign start     = start_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_q <= '0;
    end else if (state == IDLE && bus.i_req_valid) begin
      start_q <= req_start;
    end
  end
`else
  assign req_start = '0;
  assign start     = '0;
`endif

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [IW-1:0]         slot);
    word_addr = b + (ADDR_WIDTH'(slot) << WB);
  endfunction

  assign req_base       = bus.i_req_addr & BASE_MASK;
  assign issue_nxt      = issue_cnt + CW'(1);
  // Slot arithmetic truncates to IW bits, giving the modulo-LINE_SIZE wrap for free.
  assign issue_slot_nxt = start + issue_nxt[IW-1:0];
  assign recv_slot      = start + recv_cnt[IW-1:0];

  // o_mem_addr is precomputed one step ahead so it is stable for the whole handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      issue_cnt        <= '0;
      recv_cnt         <= '0;
      bus.o_req_ready  <= 1'b1;
      bus.o_mem_valid  <= 1'b0;
      bus.o_line_valid <= 1'b0;
      bus.o_line_addr  <= '0;
      bus.o_mem_addr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            base            <= req_base;
            issue_cnt       <= '0;
            recv_cnt        <= '0;
            bus.o_req_ready <= 1'b0;
            bus.o_mem_valid <= 1'b1;
            bus.o_mem_addr  <= word_addr(req_base, req_start);
            state           <= FILL;
          end
        end
        FILL: begin
          if (bus.o_mem_valid && bus.i_mem_ready) begin
            issue_cnt <= issue_nxt;
            if (issue_cnt == LAST_IDX) begin
              bus.o_mem_valid <= 1'b0;
            end else begin
              bus.o_mem_addr <= word_addr(base, issue_slot_nxt);
            end
          end
          if (bus.i_mem_valid) begin
            recv_cnt <= recv_cnt + CW'(1);
            if (recv_cnt == LAST_IDX) begin
              bus.o_line_valid <= 1'b1;
              bus.o_line_addr  <= base;
              state            <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.i_line_ready) begin
            bus.o_line_valid <= 1'b0;
            bus.o_req_ready  <= 1'b1;
            state            <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The line buffer is deliberately not reset; only FILL-state returns may write it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == FILL && bus.i_mem_valid) begin
      line_buf[recv_slot] <= bus.i_mem_data;
    end
  end

  for (genvar k = 0; k < LINE_SIZE; k++) begin : g_line_out
    assign bus.o_line_data[k] = line_buf[k];
  end

endmodule

// File: tb/tb_kv_line_fetcher.sv
// tb/tb_kv_line_fetcher.sv - directed plus randomized self-checking bench for kv_line_fetcher
module tb_kv_line_fetcher;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LS = 4;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kv_line_fetcher_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS)) bus ();

  kv_line_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_line [LS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Model: reads go out as base + ((start+k) mod LS)*4, and line word k is memory at base + 4k.
  task automatic fill(input logic [31:0] a, input int mode, input int stall, input int abort_at);
    logic [31:0] base;
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];
    int start, issued, recv, cyc, ri;
    bit r;
    base   = a & 32'hFFFF_FFF0;
    start  = CWF ? int'(a[3:2]) : 0;
    issued = 0; recv = 0; ri = 0;
    for (int k = 0; k < LS; k++) exp_q.push_back(base + 32'(((start + k) % LS) * 4));

    check($sformatf("req_ready_before_%h", a), {31'b0, bus.o_req_ready}, 32'd1);
    bus.i_req_addr  = a;
    bus.i_req_valid = 1'b1;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    cyc = 1;
    while (!bus.o_line_valid && cyc < 200) begin
      if (issued >= LS) check("mem_valid_after_last", {31'b0, bus.o_mem_valid}, 32'd0);
      if (bus.o_mem_valid && issued < LS)
        check($sformatf("mem_addr_%0d", issued), bus.o_mem_addr, exp_q[issued]);
      case (mode)
        0:       r = 1'b1;
        1:       r = (ri % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ri++;
      bus.i_mem_ready = r;
      if (pend.size() > 0 && (mode == 0 || $urandom_range(0, 2) != 0)) begin
        bus.i_mem_valid = 1'b1;
        bus.i_mem_data  = mem_rd(pend.pop_front());
        recv++;
      end else begin
        bus.i_mem_valid = 1'b0;
        bus.i_mem_data  = $urandom;
      end
      if (bus.o_mem_valid && r) begin
        pend.push_back(bus.o_mem_addr);
        issued++;
      end
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && recv == abort_at) begin
        bus.i_mem_valid = 1'b0;
        bus.i_mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
        check("abort_req_ready", {31'b0, bus.o_req_ready}, 32'd1);
        check("abort_line_valid", {31'b0, bus.o_line_valid}, 32'd0);
        return;
      end
    end
    bus.i_mem_valid = 1'b0;
    bus.i_mem_ready = 1'b0;
    check("line_valid_reached", {31'b0, bus.o_line_valid}, 32'd1);
    if (mode == 0) check("fill_latency", cyc, 32'd6);
    check("req_handshakes", issued, LS);
    check("responses", recv, LS);
    check("line_addr", bus.o_line_addr, base);
    for (int k = 0; k < LS; k++) begin
      last_line[k] = mem_rd(base + 32'(k * 4));
      check($sformatf("line_word_%0d", k), bus.o_line_data[k], last_line[k]);
    end
    for (int s = 0; s < stall; s++) begin
      bus.i_line_ready = 1'b0;
      bus.i_mem_valid  = (s == 0);
      bus.i_mem_data   = $urandom;
      @(negedge clk);
      bus.i_mem_valid = 1'b0;
      check("resp_hold_valid", {31'b0, bus.o_line_valid}, 32'd1);
      check("resp_req_ready", {31'b0, bus.o_req_ready}, 32'd0);
      for (int k = 0; k < LS; k++)
        check($sformatf("resp_hold_word_%0d", k), bus.o_line_data[k], last_line[k]);
    end
    bus.i_line_ready = 1'b1;
    @(negedge clk);
    bus.i_line_ready = 1'b0;
    check("exit_line_valid", {31'b0, bus.o_line_valid}, 32'd0);
    check("exit_req_ready", {31'b0, bus.o_req_ready}, 32'd1);
  endtask

  initial begin
    bus.i_req_addr   = '0;
    bus.i_req_valid  = 1'b0;
    bus.i_line_ready = 1'b0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_data   = '0;
    bus.i_mem_valid  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_line_addr", bus.o_line_addr, 32'd0);
    check("rst_mem_addr", bus.o_mem_addr, 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("idle_req_ready", {31'b0, bus.o_req_ready}, 32'd1);
      check("idle_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
      check("idle_line_valid", {31'b0, bus.o_line_valid}, 32'd0);
      @(negedge clk);
    end

    mem[32'h1000_1000] = 32'h0000_5555;
    mem[32'h1000_1004] = 32'h5555_0000;
    mem[32'h1000_1008] = 32'h5555_5555;
    mem[32'h1000_100C] = 32'h0505_0505;
    fill(32'h1000_1008, 0, 0, -1);

    fill(32'h1000_2004, 1, 3, -1);

    bus.i_mem_valid = 1'b1;
    bus.i_mem_data  = $urandom;
    @(negedge clk);
    bus.i_mem_valid = 1'b0;
    for (int k = 0; k < LS; k++)
      check($sformatf("spurious_idle_word_%0d", k), bus.o_line_data[k], last_line[k]);

    fill(32'hFFFF_FFF4, 0, 1, -1);

    fill(32'h3000_0048, 0, 0, 2);
    fill(32'h2000_0000, 0, 0, -1);

    for (int i = 0; i < 8; i++)
      fill($urandom, 2, $urandom_range(0, 3), -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/kv_line_fetcher.md
Name: kv_line_fetcher

Overview:
Memory-side fill engine directly downstream of the KVCache fetch port. Accepts one line-fill request (address) from the cache and issues LINE_SIZE single-word reads to the memory subsystem. Assembles the returned words into a line buffer and hands the full line back to the cache over a valid/ready response channel. Handles one line at a time. Up to LINE_SIZE word reads may be outstanding; memory returns data in issue order.

Parameters:
DATA_WIDTH, 32, word width in bits; a multiple of 8.
ADDR_WIDTH, 32, byte address width.
LINE_SIZE, 4, words per line; a power of 2, at least 2.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_req_addr  in  ADDR_WIDTH  fill address from cache; any byte within the line
i_req_valid  in  1  fill request valid
o_req_ready  out  1  fetcher can accept a request
o_line_data  out  DATA_WIDTH x LINE_SIZE (unpacked array [LINE_SIZE-1:0])  assembled line; element k = word k of line
o_line_addr  out  ADDR_WIDTH  line-aligned base address of o_line_data
o_line_valid  out  1  line complete
i_line_ready  in  1  cache accepts line
o_mem_addr  out  ADDR_WIDTH  word read address, word-aligned
o_mem_valid  out  1  word read request valid
i_mem_ready  in  1  memory accepts read request
i_mem_data  in  DATA_WIDTH  read data
i_mem_valid  in  1  read data valid; no backpressure

Behaviour:
- One clock, i_clk. i_rst is synchronous and active-high.
- Derived values: BYTES = DATA_WIDTH/8. OFS = log2(LINE_SIZE*BYTES). CW = log2(LINE_SIZE)+1 bits for the counters.
- Reset values: state=IDLE; issue_cnt=0; recv_cnt=0; o_req_ready=1; o_mem_valid=0; o_line_valid=0; o_line_addr=0; o_mem_addr=0. The line buffer is not cleared.
- States:
  - IDLE: o_req_ready=1.
    - On i_req_valid, capture base = i_req_addr with bits [OFS-1:0] cleared.
    - Capture start = i_req_addr[OFS-1:log2(BYTES)] when the feature is enabled; otherwise start=0.
    - Clear both counters and go to FILL.
  - FILL: o_req_ready=0.
    - Requests: o_mem_valid=1 while issue_cnt<LINE_SIZE.
    - o_mem_addr = base + (((start+issue_cnt) mod LINE_SIZE) * BYTES).
    - issue_cnt increments on each cycle with o_mem_valid and i_mem_ready both high.
    - Responses: on i_mem_valid, write i_mem_data into slot (start+recv_cnt) mod LINE_SIZE and increment recv_cnt.
    - Request and response may occur in the same cycle; both counters advance independently.
    - When i_mem_valid arrives with recv_cnt==LINE_SIZE-1, go to RESP on the next edge.
    - issue_cnt is guaranteed to be LINE_SIZE by then.
  - RESP: o_line_valid=1 and o_line_addr=base.
    - o_line_data is stable while o_line_valid=1.
    - On i_line_ready, go to IDLE.
    - o_req_ready returns to 1 on the following cycle; there is no request accept in the RESP-exit cycle.
- Latency: with an always-ready memory returning data one cycle after each request, o_line_valid rises LINE_SIZE+2 cycles after request acceptance.
- o_mem_valid is asserted only in FILL with issue_cnt<LINE_SIZE. Once asserted, the address holds until the handshake completes.
- i_mem_valid in IDLE or RESP is spurious: it is dropped and the buffer is unchanged.
- i_req_valid outside IDLE is ignored (not accepted).
- Reset mid-FILL or mid-RESP: return to IDLE next cycle; counters are cleared. Outstanding memory reads are not drained; the memory subsystem shares the same reset.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The slot index wraps modulo LINE_SIZE.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: start = word index of i_req_addr within the line. Reads issue in wrapped order starting from the requested word. Each word still lands in its natural slot, so o_line_data is identical to the no-feature case.
- Undefined: start is tied to 0. Reads always issue from word 0 upward. The start-index register is absent.

Test Plan:
- Reset, idle: assert i_rst 2 cycles, then release -> o_req_ready=1, o_mem_valid=0, o_line_valid=0; no state change for 5 idle cycles.
- Basic fill, feature off: req 0x1000_1008; memory always ready, returns 0x0000_5555, 0x5555_0000, 0x5555_5555, 0x0505_0505 one cycle after each request -> o_mem_addr sequence 0x1000_1000/04/08/0C; o_line_addr=0x1000_1000; line[0..3] equal the returned data in that order; o_line_valid at cycle 6.
- Critical word first, feature on: req 0x1000_1008 -> o_mem_addr sequence 08, 0C, 00, 04. Returned data D0..D3 land as line[2]=D0, line[3]=D1, line[0]=D2, line[1]=D3.
- Backpressure: i_mem_ready toggles 1,0,0,1,…; i_line_ready=0 for 3 cycles in RESP -> o_mem_addr holds while stalled; exactly 4 request handshakes; o_line_valid and o_line_data stable until i_line_ready, then IDLE.
- Spurious and wrap: i_mem_valid pulse while IDLE -> buffer unchanged. Then req 0xFFFF_FFF4 -> base 0xFFFF_FFF0, addresses FFF0..FFFC, no overflow corruption.
- Reset mid-fill: assert i_rst after 2 of 4 responses -> IDLE next cycle, o_mem_valid=0. A new req 0x2000_0000 then completes with correct line contents.
